cs_final_adder: RTL and testbench
=================================

// Module: cs_final_adder
// PURPOSE
//  Final carry-propagate stage for the compressor-based multiplier. Consumes the
//  carry-save pair (sum/carry vectors) from the 4:2 compressor output registers.
//  Produces the binary product via a segmented, pipelined adder with carry
//  registered between segments.
//  Valid/ready on both sides; sits directly downstream of the multiplier core.
// PARAMETERS
//  WIDTH     128  width of each carry-save input vector and of out_sum
//  SEG_WIDTH 32   bits added per pipeline stage; WIDTH % SEG_WIDTH == 0 required
//  (localparam NSEG = WIDTH/SEG_WIDTH, default 4 = pipeline depth)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_a/in_b hold a valid carry-save pair
//  in_ready   out  1      stage accepts input this cycle
//  in_a       in   WIDTH  carry-save vector A (sum)
//  in_b       in   WIDTH  carry-save vector B (carry)
//  out_valid  out  1      out_sum/out_cout valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_sum    out  WIDTH  (in_a + in_b) mod 2^WIDTH
//  out_cout   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Transfer on either side only when valid & ready are both high in the same cycle.
//  - Stage k (k=0..NSEG-1) adds segment k of the operands plus the carry registered by stage k-1.
//    Stage 0 carry-in = 0.
//  - Operand segments > k and result segments < k travel in skew registers alongside.
//    Registers are allocated per stage as needed; never the full width everywhere.
//  - Latency: input accepted at edge N -> out_valid=1 after edge N+NSEG (4 by default) if unstalled.
//  - Throughput: one result per cycle; results leave in acceptance order.
//  - Advance: adv = ~out_valid | out_ready. All stage registers load only when adv=1.
//    in_ready = adv (combinational from out_ready). Bubbles (valid=0) propagate as holes.
//  - Stall: out_ready=0 with out_valid=1 -> out_sum, out_cout, out_valid held stable.
//    All in-flight entries are held; nothing is dropped or duplicated.
//  - Reset: every stage valid bit = 0, out_valid=0, out_sum=0, out_cout=0 after the edge with rst=1.
//    Reset mid-operation discards all in-flight entries; none is emitted afterwards.
//    in_ready=1 in the first cycle after reset.
//  - Carry ripple: a carry generated in segment 0 can reach out_cout.
//    Example: all-ones + 1 gives out_cout=1 and out_sum=0; no early or late segment mixing.
//  - No X on outputs after reset, regardless of in_a/in_b while in_valid=0.
// CONFIGURATION
//  CS_FINAL_ADDER_SKID_EN defined:
//    - Adds a 2-entry output skid buffer. in_ready becomes a registered signal,
//      removing the out_ready->in_ready combinational path.
//    - in_ready=0 only when both skid entries are occupied.
//    - Latency to first out_valid becomes NSEG+1. Full throughput is kept.
//    - Reset clears both entries.
//  Not defined: behaviour exactly as above (combinational in_ready, latency NSEG).
// STRUCTURE
//  - Shared package mult_pkg:
//    - MULT_IN_WIDTH=64 and PROD_WIDTH=128 constants.
//    - typedef cs_pair_t {logic [PROD_WIDTH-1:0] a, b;} shared with the multiplier core.
//  - Sub-module cpa_segment: SEG_WIDTH adder, ports (a, b, cin, sum, cout), purely combinational.
//    Instantiated NSEG times with a generate loop.
//  - Top holds the pipeline/skew registers, valid chain and optional skid buffer.
// TESTING
//  1 Ripple: in_a='1 (all ones), in_b=128'h1 -> after 4 cycles out_sum=0, out_cout=1.
//  2 Stream: 8 back-to-back pairs (a=i<<60, b=i), out_ready=1 -> 8 results on 8 consecutive cycles.
//    Each result = (i<<60)+i, in order, with no gaps.
//  3 Backpressure: fill pipeline, then out_ready=0 for 5 cycles.
//    -> in_ready=0, outputs frozen. Release gives all results once, in order.
//  4 Reset mid-flight: 2 pairs accepted, rst=1 one cycle.
//    -> out_valid=0 next cycle, neither pair ever emitted, in_ready=1.
//  5 Bubbles: in_valid toggling 1/0 with a=64'hFFFF_FFFF_0000_0000, b=64'h1_0000_0000.
//    -> out_valid pattern matches with 4-cycle delay, out_sum=128'h1_0000_0000_0000_0000.
//  6 Random: 10k pairs with random out_ready, scoreboard {out_cout,out_sum}==a+b (129-bit).
//    Run with and without CS_FINAL_ADDER_SKID_EN.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: widths and carry-save pair type shared by the multiplier core and the final adder
package mult_pkg;
    localparam int MULT_IN_WIDTH = 64;
    localparam int PROD_WIDTH = 2 * MULT_IN_WIDTH;
    typedef struct packed {
        logic [PROD_WIDTH-1:0] a;
        logic [PROD_WIDTH-1:0] b;
    } cs_pair_t;
endpackage

// File: rtl/cpa_segment.sv
// cpa_segment: combinational SEG_WIDTH-bit slice of the final carry-propagate adder
module cpa_segment #(
    parameter int SEG_WIDTH = 32
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
endmodule

// File: rtl/cs_final_adder.sv
// cs_final_adder: segmented, pipelined carry-propagate adder turning a carry-save pair into a binary sum.
// Define CS_FINAL_ADDER_SKID_EN for a 2-entry output skid buffer and a registered in_ready.
module cs_final_adder
    import mult_pkg::*;
#(
    parameter int WIDTH = PROD_WIDTH,
    parameter int SEG_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int NSEG = WIDTH / SEG_WIDTH;
    logic adv;
    // Level k word: {pending (b_j, a_j) pairs for segments >= k, finished sum segments < k}.
    // Each level drops one segment, so widths shrink from 2*WIDTH down to WIDTH.
    for (genvar k = 0; k <= NSEG; k++) begin : g_lvl
        localparam int LW = 2 * WIDTH - k * SEG_WIDTH;
        logic [LW-1:0] w_d, w_q;
        logic vin, c_d, v_q, c_q;
        if (k == 0) begin : g_in
            assign vin = in_valid;
            assign c_d = 1'b0;
            always_comb begin
                w_d = '0;
                for (int j = 0; j < NSEG; j++) begin
                    w_d[2*j*SEG_WIDTH +: SEG_WIDTH] = in_a[j*SEG_WIDTH +: SEG_WIDTH];
                    w_d[(2*j+1)*SEG_WIDTH +: SEG_WIDTH] = in_b[j*SEG_WIDTH +: SEG_WIDTH];
                end
            end
        end else begin : g_add
            localparam int RP = (k - 1) * SEG_WIDTH;
            logic [SEG_WIDTH-1:0] s;
            cpa_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
                .a(g_lvl[k-1].w_q[RP +: SEG_WIDTH]),
                .b(g_lvl[k-1].w_q[RP+SEG_WIDTH +: SEG_WIDTH]),
                .cin(g_lvl[k-1].c_q),
                .sum(s),
                .cout(c_d)
            );
            assign vin = g_lvl[k-1].v_q;
            always_comb begin
                w_d = g_lvl[k-1].w_q[LW+SEG_WIDTH-1:SEG_WIDTH];
                w_d[0 +: k*SEG_WIDTH] = g_lvl[k-1].w_q[k*SEG_WIDTH-1:0];
                w_d[RP +: SEG_WIDTH] = s;
            end
        end
        // Data only loads behind a valid entry, so bubbles never carry garbage to the outputs.
        always_ff @(posedge clk)
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                w_q <= '0;
            end else if (adv) begin
                v_q <= vin;
                if (vin) begin
                    c_q <= c_d;
                    w_q <= w_d;
                end
            end
    end
`ifdef CS_FINAL_ADDER_SKID_EN
    logic [WIDTH:0] skid_q [2];
    logic [1:0] cnt_q;
    logic rd_q, wr_q, push, pop;
    // The pipeline only moves while the skid has a free slot, so in_ready comes straight from a flop.
    assign adv = ~cnt_q[1];
    assign in_ready = adv;
    assign push = adv & g_lvl[NSEG].v_q;
    assign pop = out_valid & out_ready;
    assign out_valid = |cnt_q;
    assign {out_cout, out_sum} = skid_q[rd_q];
    always_ff @(posedge clk)
        if (rst) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            cnt_q <= 2'd0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            if (push) begin
                skid_q[wr_q] <= {g_lvl[NSEG].c_q, g_lvl[NSEG].w_q};
                wr_q <= ~wr_q;
            end
            if (pop)
                rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
`else
    assign out_valid = g_lvl[NSEG].v_q;
    assign out_sum = g_lvl[NSEG].w_q;
    assign out_cout = g_lvl[NSEG].c_q;
    assign adv = ~out_valid | out_ready;
    assign in_ready = adv;
`endif
endmodule

// File: tb/tb_cs_final_adder.sv
// tb_cs_final_adder: scoreboard bench for cs_final_adder, default and CS_FINAL_ADDER_SKID_EN builds.
module tb_cs_final_adder;
    localparam int W = 128;
    localparam int NSEG = 4;
`ifdef CS_FINAL_ADDER_SKID_EN
    localparam int LAT = NSEG + 1;
`else
    localparam int LAT = NSEG;
`endif
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_cout;
    logic [W-1:0] out_sum;
    logic [W:0] sbq[$];
    int n_cmp = 0, n_bad = 0;

    cs_final_adder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        n_cmp++;
        if (out_cout !== 1'b0) begin n_bad++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        sbq.delete();
    endtask

    task automatic test_ripple;
        int lat = 0;
        @(posedge clk);
        #1;
        in_a = '1;
        in_b = W'(1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ripple_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            lat++;
        end
        n_cmp++;
        if (lat != LAT) begin n_bad++; $display("FAIL ripple_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if ({out_cout, out_sum} !== {1'b1, {W{1'b0}}})
            begin n_bad++; $display("FAIL ripple_result: got %b_%h want 1_0", out_cout, out_sum); end
    endtask

    task automatic test_stream;
        int first = -1, last = -1, n_out = 0, i = 0;
        logic [W:0] exp;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 + LAT + 6; cyc++) begin
            @(posedge clk);
            #1;
            in_valid = (i < 8);
            in_a = W'(i) << 60;
            in_b = W'(i);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sbq.push_back({1'b0, W'(i) << 60} + (W+1)'(i));
                i++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++; $display("FAIL stream_extra: got %h want no output", out_sum);
                end else begin
                    exp = sbq.pop_front();
                    if ({out_cout, out_sum} !== exp)
                        begin n_bad++; $display("FAIL stream_data: got %h want %h", {out_cout, out_sum}, exp); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n_out++;
            end
        end
        n_cmp++;
        if (n_out != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", n_out); end
        n_cmp++;
        if (last - first != 7) begin n_bad++; $display("FAIL stream_gaps: got span %0d want 7", last - first); end
    endtask

    task automatic test_backpressure;
        int i = 0;
        logic acc = 1'b0;
        logic [W:0] exp;
        for (int cyc = 0; cyc < LAT + 46; cyc++) begin
            @(posedge clk);
            #1;
            if (acc) i++;
            in_valid = (cyc < LAT + 6);
            in_a = {W{1'b1}} - W'(i);
            in_b = (W'(i) << 100) | W'(i + 1);
            out_ready = (cyc >= LAT + 6);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sbq.push_back({1'b0, in_a} + {1'b0, in_b});
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (sbq.size() == 0 || {out_cout, out_sum} !== sbq[0])
                    begin n_bad++; $display("FAIL bp_frozen: got %h want scoreboard head", {out_cout, out_sum}); end
            end
            if (cyc == LAT + 5) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                n_cmp++;
                if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra: got %h want no output", out_sum);
                end else begin
                    exp = sbq.pop_front();
                    if ({out_cout, out_sum} !== exp)
                        begin n_bad++; $display("FAIL bp_data: got %h want %h", {out_cout, out_sum}, exp); end
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d left want 0", sbq.size()); end
        sbq.delete();
    endtask

    task automatic test_reset_mid;
        int n_acc = 0, ghost = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a = W'(c + 5);
            in_b = W'(7);
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (n_acc != 2) begin n_bad++; $display("FAIL rstmid_accept: got %0d want 2", n_acc); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ghost++;
        end
        n_cmp++;
        if (ghost != 0) begin n_bad++; $display("FAIL rstmid_ghost: got %0d outputs want 0", ghost); end
    endtask

    task automatic test_bubbles;
        logic exp_v;
        logic [W:0] exp;
        out_ready = 1'b1;
        for (int j = 0; j < 16 + LAT + 2; j++) begin
            @(posedge clk);
            #1;
            in_valid = (j < 16) && (j % 2 == 0);
            in_a = W'(64'hFFFF_FFFF_0000_0000);
            in_b = W'(64'h1_0000_0000);
            @(negedge clk);
            if (in_valid && in_ready) sbq.push_back(129'h1_0000_0000_0000_0000);
            exp_v = (j - LAT - 1 >= 0) && (j - LAT - 1 < 16) && ((j - LAT - 1) % 2 == 0);
            n_cmp++;
            if (out_valid !== exp_v)
                begin n_bad++; $display("FAIL bubble_valid[%0d]: got %b want %b", j, out_valid, exp_v); end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++; $display("FAIL bubble_extra: got %h want no output", out_sum);
                end else begin
                    exp = sbq.pop_front();
                    if ({out_cout, out_sum} !== exp)
                        begin n_bad++; $display("FAIL bubble_data: got %h want %h", {out_cout, out_sum}, exp); end
                end
            end
        end
    endtask

    task automatic test_random;
        int sent = 0, cyc = 0;
        logic acc = 1'b0;
        logic [W:0] exp;
        in_valid = 1'b0;
        while ((sent < 10000 || sbq.size() != 0) && cyc < 60000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            if (!in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_a = {$urandom, $urandom, $urandom, $urandom};
                in_b = ($urandom_range(0, 7) == 0) ? ~in_a + W'($urandom_range(0, 1))
                                                   : {$urandom, $urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sbq.push_back({1'b0, in_a} + {1'b0, in_b});
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra: got %h want no output", out_sum);
                end else begin
                    exp = sbq.pop_front();
                    if ({out_cout, out_sum} !== exp)
                        begin n_bad++; $display("FAIL rand_data: got %h want %h", {out_cout, out_sum}, exp); end
                end
            end
        end
        n_cmp++;
        if (sent != 10000 || sbq.size() != 0)
            begin n_bad++; $display("FAIL rand_drain: got sent=%0d left=%0d want 10000/0", sent, sbq.size()); end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_ripple;
        test_stream;
        test_backpressure;
        test_reset_mid;
        test_bubbles;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
